// File: rtl/x_23k640_slave.sv
// x_23k640_slave: SPI-side model of a 23K640 serial SRAM (mode 0).
// Oversamples CS/SCK/SI on i_clk. Decodes READ (0x03), WRITE (0x02),
// RDSR (0x05) and WRSR (0x01). The array is an on-chip RAM with a
// dedicated backdoor read port.
//
// Ports:
//   i_clk       system clock (>=4x SCK, >=8x with synchronizers)
//   i_rst       synchronous active-high reset; array contents are kept
//   i_cs        SPI chip select, active low
//   i_sck       SPI clock, idle low
//   i_si        serial data in (master -> slave)
//   o_so        serial data out; 0 when not driving read/status data
//   o_status    status register {mode[1:0], 5'b0, bit0}
//   i_bd_addr   backdoor read address
//   o_bd_rdata  backdoor read data, registered (one cycle latency)
//
// Build option: define X_23K640_SLAVE_SYNC_EN to add 2-flop synchronizers
// on i_cs, i_sck and i_si for asynchronous pins.
module x_23k640_slave #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_sck,
  input  logic              i_si,
  output logic              o_so,
  output logic [7:0]        o_status,
  input  logic [ADDR_W-1:0] i_bd_addr,
  output logic [7:0]        o_bd_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_ST_RD, S_ST_WR, S_IGNORE
  } state_e;

  // Pin conditioning: {cs, sck, si}
  logic [2:0] pins_d;
`ifdef X_23K640_SLAVE_SYNC_EN
  logic [2:0] sync1_q, sync2_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_cs, i_sck, i_si};
      sync2_q <= sync1_q;
    end
  end
  assign pins_d = sync2_q;
`else
  assign pins_d = {i_cs, i_sck, i_si};
`endif

  // cs_q/cs_prev_q reset low so that a CS held low across reset is not
  // mistaken for a new CS fall; the master must toggle CS first.
  logic cs_q, sck_q, si_q, cs_prev_q, sck_prev_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_q       <= 1'b0;
      sck_q      <= 1'b0;
      si_q       <= 1'b0;
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      {cs_q, sck_q, si_q} <= pins_d;
      cs_prev_q  <= cs_q;
      sck_prev_q <= sck_q;
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise = sck_q & ~sck_prev_q;
  assign sck_fall = ~sck_q & sck_prev_q;

  state_e            state_q;
  logic [ADDR_W-2:0] rx_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        tx_q;
  logic              so_q;
  logic [7:0]        status_q;
  logic [ADDR_W-1:0] addr_q;
  logic              is_rd_q;
  logic              load_q;
  logic              done_q;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [7:0]        wd_q;
  logic [7:0]        bd_q;
  logic [7:0]        mem_q [2**ADDR_W];

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_word;
  assign rx_byte = {rx_q[6:0], si_q};
  assign rx_word = {rx_q, si_q};

  // Post-byte address advance; modes 00 and 11 both stop after one byte.
  logic [ADDR_W-1:0] addr_next_d;
  logic              byte_mode;
  assign byte_mode = (status_q[7] == status_q[6]);
  always_comb begin
    addr_next_d = addr_q;
    case (status_q[7:6])
      2'b01:   addr_next_d = addr_q + ADDR_W'(1);
      2'b10:   addr_next_d = {addr_q[ADDR_W-1:5], addr_q[4:0] + 5'd1};
      default: addr_next_d = addr_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      so_q      <= 1'b0;
      status_q  <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      we_q   <= 1'b0;
      load_q <= 1'b0;
      // One-cycle RAM read; lands well before the next SCK fall.
      if (load_q) tx_q <= done_q ? '0 : mem_q[addr_q];
      if (cs_q) begin
        state_q   <= S_IDLE;
        so_q      <= 1'b0;
        bit_cnt_q <= '0;
        done_q    <= 1'b0;
      end else begin
        if (sck_rise) rx_q <= rx_word[ADDR_W-2:0];
        case (state_q)
          S_IDLE: begin
            if (cs_prev_q) begin
              state_q   <= S_CMD;
              bit_cnt_q <= '0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                case (rx_byte)
                  8'h03: begin state_q <= S_ADDR; is_rd_q <= 1'b1; end
                  8'h02: begin state_q <= S_ADDR; is_rd_q <= 1'b0; end
                  8'h05: begin state_q <= S_ST_RD; tx_q <= status_q; end
                  8'h01: state_q <= S_ST_WR;
                  default: state_q <= S_IGNORE;
                endcase
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                bit_cnt_q <= '0;
                addr_q    <= rx_word;
                done_q    <= 1'b0;
                state_q   <= is_rd_q ? S_RD_DATA : S_WR_DATA;
                load_q    <= is_rd_q;
              end
            end
          end
          S_RD_DATA, S_WR_DATA: begin
            if (sck_fall && state_q == S_RD_DATA) begin
              so_q <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
            end
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (state_q == S_RD_DATA) load_q <= 1'b1;
                else if (!done_q) begin
                  we_q <= 1'b1;
                  wa_q <= addr_q;
                  wd_q <= rx_byte;
                end
                if (byte_mode || done_q) done_q <= 1'b1;
                else addr_q <= addr_next_d;
              end
            end
          end
          S_ST_RD: begin
            if (sck_fall) begin
              so_q <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
            end
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                tx_q      <= status_q;
              end
            end
          end
          S_ST_WR: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                status_q <= rx_byte & 8'hC1;
                state_q  <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_q) mem_q[wa_q] <= wd_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) bd_q <= '0;
    else       bd_q <= mem_q[i_bd_addr];
  end

  assign o_so       = so_q;
  assign o_status   = status_q;
  assign o_bd_rdata = bd_q;

endmodule
